bin_frame_writer: RTL

Write side of the binary frame buffer used by the 5x5 morphology stage. Accepts the 1-bit binarized camera pixel stream over a valid/ready handshake, generates linear write addresses into the 488x302 single-bit SDPB frame buffer (port A), and signals frame completion. It then holds the buffer until the morphology reader releases it, so a frame is never overwritten while it is being filtered.

---
 rtl/bin_img_pkg.sv | 16 +
 rtl/pix_pos_counter.sv | 60 ++++++
 rtl/bin_frame_writer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bin_img_pkg.sv
// Shared frame-buffer dimensions and writer state encoding.
// The morphology reader imports this package too, so both ends agree on geometry.
package bin_img_pkg;

    localparam int unsigned IMG_W        = 488;
    localparam int unsigned IMG_H        = 302;
    localparam int unsigned ADDR_W       = 18;
    localparam int unsigned FRAME_PIXELS = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        WRITE    = 2'd1,
        DONE     = 2'd2
    } wr_state_t;

endpackage

// File: rtl/pix_pos_counter.sv
// Column/row/linear pixel position counters for the frame writer.
// clear restarts at (0,0); clear together with advance lands on the pixel after (0,0).
module pix_pos_counter #(
    parameter int unsigned IMG_W  = bin_img_pkg::IMG_W,
    parameter int unsigned IMG_H  = bin_img_pkg::IMG_H,
    parameter int unsigned ADDR_W = bin_img_pkg::ADDR_W
) (
    input  logic              clk_out,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0]  col_q, col_base, col_d;
    logic [ROW_W-1:0]  row_q, row_base, row_d;
    logic [ADDR_W-1:0] addr_q, addr_base, addr_d;
    logic              col_end, row_end;

    // Step from either the current position or (0,0); the last pixel wraps everything to 0.
    always_comb begin
        col_base  = clear ? '0 : col_q;
        row_base  = clear ? '0 : row_q;
        addr_base = clear ? '0 : addr_q;
        col_end   = (col_base == COL_W'(IMG_W - 1));
        row_end   = (row_base == ROW_W'(IMG_H - 1));
        col_d     = col_base;
        row_d     = row_base;
        addr_d    = addr_base;
        if (advance) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_base + ROW_W'(1);
            end else begin
                col_d = col_base + COL_W'(1);
            end
            addr_d = (col_end && row_end) ? '0 : addr_base + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign addr   = addr_q;
    assign last_c = (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1));

endmodule

// File: rtl/bin_frame_writer.sv
// Write side of the binary frame buffer: pixel handshake, linear write addressing,
// frame completion and hold-until-release so a frame is never overwritten mid-filter.
module bin_frame_writer #(
    parameter int unsigned IMG_W  = bin_img_pkg::IMG_W,
    parameter int unsigned IMG_H  = bin_img_pkg::IMG_H,
    parameter int unsigned ADDR_W = bin_img_pkg::ADDR_W
) (
    input  logic              clk_out,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic              pix_data,
    input  logic              pix_sof,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              frame_done,
    input  logic              frame_release,
    output logic              busy,
    output logic              sync_err,
    input  logic              err_clr
);

    import bin_img_pkg::*;

    localparam longint unsigned FRAME_PIXELS = longint'(IMG_W) * longint'(IMG_H);
    localparam bit              ONE_PIXEL    = (FRAME_PIXELS == 64'd1);

    if (FRAME_PIXELS > (64'd1 << ADDR_W)) begin : g_addr_w_check
        $error("bin_frame_writer: IMG_W*IMG_H does not fit in ADDR_W address bits");
    end

    wr_state_t         state, next_state;
    logic              cnt_clear, cnt_adv;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_last_c;
    logic              wr_c, done_c, err_set_c;
    logic [ADDR_W-1:0] addr_c;

    pix_pos_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_pos (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .addr    (cnt_addr),
        .last_c  (cnt_last_c)
    );

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) state <= WAIT_SOF;
        else        state <= next_state;
    end

    // Next state and per-beat control; pix_ready is registered so it equals (state != DONE).
    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_adv    = 1'b0;
        wr_c       = 1'b0;
        done_c     = 1'b0;
        err_set_c  = 1'b0;
        unique case (state)
            WAIT_SOF: begin
                if (pix_valid && pix_sof) begin
                    cnt_clear = 1'b1;
                    cnt_adv   = 1'b1;
                    wr_c      = 1'b1;
                    if (ONE_PIXEL) begin
                        done_c     = 1'b1;
                        next_state = DONE;
                    end else begin
                        next_state = WRITE;
                    end
                end
            end
            WRITE: begin
                if (pix_valid) begin
                    wr_c    = 1'b1;
                    cnt_adv = 1'b1;
                    if (pix_sof) begin
                        cnt_clear = 1'b1;
                        err_set_c = 1'b1;
                    end else if (cnt_last_c) begin
                        done_c     = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (frame_release) begin
                    cnt_clear  = 1'b1;
                    next_state = WAIT_SOF;
                end
            end
            default: next_state = WAIT_SOF;
        endcase
        addr_c = cnt_clear ? '0 : cnt_addr;
    end

    // Output registers: write strobe/address/data lag acceptance by one cycle.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            pix_ready  <= 1'b1;
            busy       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            pix_ready  <= (next_state != DONE);
            busy       <= (next_state != WAIT_SOF);
            wr_en      <= wr_c;
            frame_done <= done_c;
            sync_err   <= err_set_c | (sync_err & ~err_clr);
            if (wr_c) begin
                wr_addr <= addr_c;
                wr_data <= pix_data;
            end
        end
    end

endmodule
